// File: rtl/controller_if.sv
// Status and control bundle between the game controller and its datapath.
// The controller takes the slave side; the testbench or datapath wrapper takes the master side.
interface controller_if;
    logic       enter;
    logic       end_fpga;
    logic       end_user;
    logic       end_time;
    logic       win;
    logic       match;
    logic       r1;
    logic       r2;
    logic       e1;
    logic       e2;
    logic       e3;
    logic       e4;
    logic       sel;
    logic [2:0] state;

    modport master (
        output enter, end_fpga, end_user, end_time, win, match,
        input  r1, r2, e1, e2, e3, e4, sel, state
    );

    modport slave (
        input  enter, end_fpga, end_user, end_time, win, match,
        output r1, r2, e1, e2, e3, e4, sel, state
    );
endinterface

// File: rtl/controller.sv
// Moore FSM sequencing a memory game: setup, FPGA playback, user entry, check, result.
// The asynchronous enter button is synchronized and edge-detected into a single-cycle pulse.
module controller (
    input  logic         clock_50,
    input  logic         R,
    controller_if.slave  bus
);
    localparam logic [2:0] S_INIT       = 3'd0;
    localparam logic [2:0] S_SETUP      = 3'd1;
    localparam logic [2:0] S_PLAY_FPGA  = 3'd2;
    localparam logic [2:0] S_PLAY_USER  = 3'd3;
    localparam logic [2:0] S_CHECK      = 3'd4;
    localparam logic [2:0] S_NEXT_ROUND = 3'd5;
    localparam logic [2:0] S_RESULT     = 3'd6;

    logic [2:0] state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       hist_q, hist_d;
    logic       enter_pulse;

    logic r1, r2, e1, e2, e3, e4, sel;

    assign sync1_d     = bus.enter;
    assign sync2_d     = sync1_q;
    assign hist_d      = sync2_q;
    assign enter_pulse = sync2_q & ~hist_q;

    always_ff @(posedge clock_50 or posedge R) begin
        if (R) begin
            state_q <= S_INIT;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:       state_d = S_SETUP;
            S_SETUP:      if (enter_pulse) state_d = S_PLAY_FPGA;
            S_PLAY_FPGA:  if (bus.end_fpga) state_d = S_PLAY_USER;
            S_PLAY_USER: begin
                // Timeout outranks a simultaneous confirm.
                if (bus.end_time)      state_d = S_RESULT;
                else if (enter_pulse)  state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!bus.match)                     state_d = S_RESULT;
                else if (bus.end_user && bus.win)   state_d = S_RESULT;
                else if (bus.end_user)              state_d = S_NEXT_ROUND;
                else                                state_d = S_PLAY_USER;
            end
            S_NEXT_ROUND: state_d = S_PLAY_FPGA;
            S_RESULT:     if (enter_pulse) state_d = S_INIT;
            default:      state_d = S_INIT;
        endcase
    end

    always_comb begin
        r1  = 1'b0;
        r2  = 1'b0;
        e1  = 1'b0;
        e2  = 1'b0;
        e3  = 1'b0;
        e4  = 1'b0;
        sel = 1'b0;
        case (state_q)
            S_SETUP:      e1 = 1'b1;
            S_PLAY_FPGA:  begin e3 = 1'b1; r2 = 1'b1; end
            S_PLAY_USER:  e2 = 1'b1;
            S_CHECK:      begin e4 = 1'b1; r2 = 1'b1; end
            S_NEXT_ROUND: r2 = 1'b1;
            S_RESULT:     sel = 1'b1;
            // INIT and the unused code both hold the datapath in reset.
            default:      begin r1 = 1'b1; r2 = 1'b1; end
        endcase
    end

    assign bus.r1    = r1;
    assign bus.r2    = r2;
    assign bus.e1    = e1;
    assign bus.e2    = e2;
    assign bus.e3    = e3;
    assign bus.e4    = e4;
    assign bus.sel   = sel;
    assign bus.state = state_q;
endmodule

// File: tb/tb_controller.sv
// Directed scenarios plus randomized play checked each cycle against a behavioural model
// of the game rules and the enter edge detector.
module tb_controller;
    logic clock_50;
    logic R;
    controller_if bus ();

    controller dut (
        .clock_50 (clock_50),
        .R        (R),
        .bus      (bus.slave)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model: game state plus the last three enter samples (s1 newest).
    int m_state;
    bit s1, s2, s3;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    // {r1,r2,e1,e2,e3,e4,sel} expected for each state code.
    function automatic logic [6:0] exp_out(input int s);
        case (s)
            1:       return 7'b0010000;
            2:       return 7'b0100100;
            3:       return 7'b0001000;
            4:       return 7'b0100010;
            5:       return 7'b0100000;
            6:       return 7'b0000001;
            default: return 7'b1100000;
        endcase
    endfunction

    function automatic int next_state(input int s, input bit pulse);
        case (s)
            0: return 1;
            1: return pulse ? 2 : 1;
            2: return bus.end_fpga ? 3 : 2;
            3: return bus.end_time ? 6 : (pulse ? 4 : 3);
            4: begin
                if (!bus.match)                  return 6;
                if (bus.end_user && bus.win)     return 6;
                if (bus.end_user)                return 5;
                return 3;
            end
            5: return 2;
            6: return pulse ? 0 : 6;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        s1 = 0; s2 = 0; s3 = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, {7'd0, bus.state}, {7'd0, 3'(m_state)});
        check({tag, "_outs"},
              {3'd0, bus.r1, bus.r2, bus.e1, bus.e2, bus.e3, bus.e4, bus.sel},
              {3'd0, exp_out(m_state)});
    endtask

    // Called just after a falling edge: drive, clock once, update model, check, return at next falling edge.
    task automatic cyc(input string tag, input bit en, input bit ef, input bit eu,
                       input bit et, input bit w, input bit m);
        bit pulse;
        bus.enter = en; bus.end_fpga = ef; bus.end_user = eu;
        bus.end_time = et; bus.win = w; bus.match = m;
        @(posedge clock_50);
        pulse   = s2 & ~s3;
        m_state = next_state(m_state, pulse);
        s3 = s2; s2 = s1; s1 = en;
        #1;
        check_all(tag);
        @(negedge clock_50);
    endtask

    // Mid-cycle reset; returns at a falling edge with R released.
    task automatic async_reset(input string tag);
        #2 R = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clock_50);
        #1;
        check_all({tag, "_held"});
        @(negedge clock_50);
        R = 1'b0;
    endtask

    task automatic pulse_enter(input string tag, input bit ef, input bit eu,
                               input bit et, input bit w, input bit m);
        cyc(tag, 1, ef, eu, et, w, m);
        cyc(tag, 0, ef, eu, et, w, m);
        cyc(tag, 0, ef, eu, et, w, m);
    endtask

    bit ent;

    initial begin
        R = 1'b1;
        bus.enter = 0; bus.end_fpga = 0; bus.end_user = 0;
        bus.end_time = 0; bus.win = 0; bus.match = 0;
        model_reset();
        #1 check_all("por");
        @(negedge clock_50);
        R = 1'b0;

        cyc("to_setup", 0, 0, 0, 0, 0, 0);

        // Full round: SETUP -> FPGA -> USER -> CHECK -> NEXT_ROUND -> FPGA.
        pulse_enter("setup_go", 0, 0, 0, 0, 0);
        cyc("fpga_done", 0, 1, 0, 0, 0, 0);
        pulse_enter("user_ok", 0, 1, 0, 0, 1);
        cyc("check_next", 0, 0, 1, 0, 0, 1);
        cyc("next_fpga", 0, 0, 1, 0, 0, 1);

        // Mismatch to RESULT, then back through INIT to SETUP.
        cyc("fpga_done2", 0, 1, 0, 0, 0, 0);
        pulse_enter("user_bad", 0, 0, 0, 0, 0);
        cyc("mismatch", 0, 0, 0, 0, 0, 0);
        pulse_enter("result_ack", 0, 0, 0, 0, 0);
        cyc("reinit", 0, 0, 0, 0, 0, 0);

        // Timeout coinciding with enter_pulse.
        pulse_enter("setup_go2", 0, 0, 0, 0, 0);
        cyc("fpga_done3", 0, 1, 0, 0, 0, 0);
        cyc("to_en", 1, 0, 0, 0, 0, 1);
        cyc("to_wait", 0, 0, 0, 0, 0, 1);
        cyc("to_race", 0, 0, 0, 1, 0, 1);
        pulse_enter("result_ack2", 0, 0, 0, 0, 0);
        cyc("reinit2", 0, 0, 0, 0, 0, 0);

        // Held enter: one pulse only, even after reaching PLAY_USER.
        for (int i = 0; i < 20; i++)
            cyc("held", 1, (i == 6), 0, 0, 0, 1);
        cyc("held_rel", 0, 0, 0, 0, 0, 1);

        // Asynchronous reset while in PLAY_USER.
        async_reset("rst_play");
        cyc("rst_setup", 0, 0, 0, 0, 0, 0);

        // Illegal code 7 drives INIT outputs and recovers on the next edge.
        force dut.state_q = 3'd7;
        #1 release dut.state_q;
        m_state = 7;
        check_all("illegal");
        cyc("illegal_exit", 0, 0, 0, 0, 0, 0);

        // Enter held high across reset release.
        bus.enter = 1;
        async_reset("rst_enter");
        for (int i = 0; i < 4; i++)
            cyc("enter_rel", 1, 0, 0, 0, 0, 0);

        // Randomized play with occasional mid-cycle resets.
        ent = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) ent = ~ent;
            if ($urandom_range(60) == 0)
                async_reset("rnd_rst");
            else
                cyc("rnd", ent, $urandom_range(2) == 0, $urandom_range(2) == 0,
                    $urandom_range(9) == 0, $urandom_range(2) == 0,
                    $urandom_range(3) != 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have one clock, clock_50; reset is asynchronous and active-high, named R.
REQ-002 Ports (name  direction  width  meaning):
- clock_50  in  1  system clock, rising edge.
- R  in  1  asynchronous active-high reset.
- enter  in  1  user confirm, active-high level, asynchronous to clock_50.
- end_fpga  in  1  datapath status: FPGA sequence display finished.
- end_user  in  1  datapath status: user has entered the full round sequence.
- end_time  in  1  datapath status: user time limit expired.
- win  in  1  datapath status: final round completed.
- match  in  1  datapath status: last user entry equals the FPGA entry.
- r1  out  1  datapath global reset.
- r2  out  1  datapath time-counter reset.
- e1  out  1  setup register load enable.
- e2  out  1  time counter enable.
- e3  out  1  FPGA sequence counter enable.
- e4  out  1  user entry register/counter enable.
- sel  out  1  display mux select: 0 = game, 1 = result.
- state  out  3  current state code, for debug display.

Function
REQ-003 enter SHALL pass through a two-flop synchronizer followed by a history flop, giving enter_pulse = sync2 & ~hist, high for exactly one cycle per rising edge of enter.
REQ-004 Holding enter high SHALL produce only one pulse; a new pulse requires enter to go low for at least one sampled cycle.
REQ-005 A rising edge of enter that meets setup at edge k SHALL change state at edge k+2, when the state permits.
REQ-006 The FSM SHALL be Moore, with outputs decoded from the state register only. The state codes are INIT=0, SETUP=1, PLAY_FPGA=2, PLAY_USER=3, CHECK=4, NEXT_ROUND=5, RESULT=6.
REQ-007 Code 7 is illegal and SHALL transition to INIT on the next edge, with INIT outputs driven while in code 7.
REQ-008 INIT: r1=1, r2=1, all other outputs 0; goes to SETUP unconditionally after one cycle.
REQ-009 SETUP: e1=1; goes to PLAY_FPGA on enter_pulse, otherwise stays.
REQ-010 PLAY_FPGA: e3=1, r2=1; goes to PLAY_USER when end_fpga=1.
REQ-011 PLAY_USER: e2=1. Priority: end_time=1 goes to RESULT; otherwise enter_pulse goes to CHECK; otherwise stays.
REQ-012 CHECK: e4=1 for exactly one cycle, r2=1. Priority:
- match=0 goes to RESULT.
- else end_user=1 and win=1 goes to RESULT.
- else end_user=1 goes to NEXT_ROUND.
- else goes to PLAY_USER.
REQ-013 NEXT_ROUND: r2=1; goes to PLAY_FPGA after one cycle.
REQ-014 RESULT: sel=1, all other outputs 0; goes to INIT on enter_pulse, otherwise stays.
REQ-015 Any output not listed for a state SHALL be 0 in that state.
REQ-016 Status inputs are synchronous to clock_50 and SHALL be sampled without synchronization; they are ignored in states where they are not listed.
REQ-017 When end_time and enter_pulse occur in the same cycle in PLAY_USER, the block SHALL go to RESULT (timeout wins).
REQ-018 The state output SHALL equal the state register code.

Reset
REQ-019 While R=1, state SHALL be INIT (0), with r1=1, r2=1, e1=e2=e3=e4=0 and sel=0, and the synchronizer and history flops cleared to 0.
REQ-020 Asserting R in any state, mid-round included, SHALL force INIT immediately, without waiting for a clock edge.
REQ-021 After R deasserts, the first edge SHALL move the FSM to SETUP.
REQ-022 An enter held high across reset release SHALL produce one enter_pulse, two edges after release.

Verification
REQ-023 Reset then release, then 1 cycle -> state=1, e1=1; r1 and r2 were 1 during INIT.
REQ-024 Full round: in SETUP pulse enter -> state 2 at edge k+2; end_fpga=1 -> state 3; enter, match=1, end_user=1, win=0 -> states 4, 5, 2 on consecutive edges; e4 high for exactly 1 cycle.
REQ-025 Mismatch: in PLAY_USER pulse enter with match=0 -> states 4 then 6, sel=1; enter again -> state 0, then 1.
REQ-026 Timeout: in PLAY_USER, end_time=1 in the same cycle as enter_pulse -> state 6, with no pass through state 4.
REQ-027 Held enter: enter high for 20 cycles in SETUP -> exactly one transition to state 2, and no second pulse while enter stays high.
REQ-028 Async reset: assert R between clock edges in state 3 -> state=0 and r1=1 before the next edge; force illegal state 7 -> state 0 on the next edge.
